mrv1_issue_sched: RTL and testbench

MRV1_ISSUE_SCHED -- requirements
Module: mrv1_issue_sched

---
 rtl/mrv1_issue_sched.sv | 170 +++++++++++++++++
 tb/tb_mrv1_issue_sched.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mrv1_issue_sched.sv
// Multi-thread issue scheduler: one-entry {insn, pc} buffer per thread, round-robin
// selection with a lock under back-pressure, and per-thread wait for branch resolution.
module mrv1_issue_sched #(
  parameter int PC_WIDTH_P    = 32,
  parameter int NUM_THREADS_P = 8,
  localparam int TID_WIDTH_LP = $clog2(NUM_THREADS_P)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_THREADS_P-1:0] thread_en_i,
  input  logic                     fetch_vld_i,
  input  logic [31:0]              fetch_insn_i,
  input  logic [PC_WIDTH_P-1:0]    fetch_pc_i,
  input  logic [TID_WIDTH_LP-1:0]  fetch_tid_i,
  output logic [NUM_THREADS_P-1:0] fetch_rdy_o,
  output logic                     insn_vld_o,
  output logic [31:0]              insn_o,
  output logic [PC_WIDTH_P-1:0]    insn_pc_o,
  output logic [TID_WIDTH_LP-1:0]  insn_tid_o,
  input  logic                     insn_rdy_i,
  input  logic                     dec_b_is_branch_i,
  input  logic                     dec_b_is_jump_i,
  input  logic                     br_resolve_vld_i,
  input  logic [TID_WIDTH_LP-1:0]  br_resolve_tid_i,
  input  logic                     flush_vld_i,
  input  logic [TID_WIDTH_LP-1:0]  flush_tid_i,
  output logic [NUM_THREADS_P-1:0] thread_idle_o
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_READY   = 2'd1,
    ST_WAIT_BR = 2'd2
  } state_e;

  state_e                    state_q [NUM_THREADS_P];
  state_e                    state_d [NUM_THREADS_P];
  logic [31:0]               insn_q  [NUM_THREADS_P];
  logic [31:0]               insn_d  [NUM_THREADS_P];
  logic [PC_WIDTH_P-1:0]     pc_q    [NUM_THREADS_P];
  logic [PC_WIDTH_P-1:0]     pc_d    [NUM_THREADS_P];
  logic [TID_WIDTH_LP-1:0]   last_grant_q, last_grant_d;
  logic                      lock_vld_q, lock_vld_d;
  logic [TID_WIDTH_LP-1:0]   lock_tid_q, lock_tid_d;

  logic [NUM_THREADS_P-1:0]  elig;
  logic [NUM_THREADS_P-1:0]  fetch_hit;
  logic                      sel_found;
  logic [TID_WIDTH_LP-1:0]   sel_tid;
  logic [TID_WIDTH_LP-1:0]   rr_cand;
  logic                      issue_hs;

  // Per-thread status: fetch readiness, idle flag and issue eligibility.
  always_comb begin
    fetch_rdy_o   = '0;
    thread_idle_o = '0;
    elig          = '0;
    fetch_hit     = '0;
    for (int t = 0; t < NUM_THREADS_P; t++) begin
      thread_idle_o[t] = (state_q[t] == ST_EMPTY);
      fetch_rdy_o[t]   = (state_q[t] == ST_EMPTY) && thread_en_i[t] && !rst_i;
      fetch_hit[t]     = fetch_rdy_o[t] && fetch_vld_i && (fetch_tid_i == TID_WIDTH_LP'(t));
      // A thread being flushed this cycle must not be offered to the decoder.
      elig[t]          = (state_q[t] == ST_READY) && thread_en_i[t] && !rst_i &&
                         !(flush_vld_i && (flush_tid_i == TID_WIDTH_LP'(t)));
    end
  end

  // Thread selection: held thread first, otherwise round-robin after last grant.
  always_comb begin
    sel_found = 1'b0;
    sel_tid   = '0;
    rr_cand   = '0;
    if (lock_vld_q && elig[lock_tid_q]) begin
      sel_found = 1'b1;
      sel_tid   = lock_tid_q;
    end else begin
      for (int i = 1; i <= NUM_THREADS_P; i++) begin
        rr_cand = TID_WIDTH_LP'((int'(last_grant_q) + i) % NUM_THREADS_P);
        if (!sel_found && elig[rr_cand]) begin
          sel_found = 1'b1;
          sel_tid   = rr_cand;
        end else begin
          sel_found = sel_found;
        end
      end
    end
  end

  // Issue outputs driven from the selected thread's buffer.
  always_comb begin
    insn_vld_o = sel_found;
    insn_tid_o = sel_tid;
    insn_o     = insn_q[sel_tid];
    insn_pc_o  = pc_q[sel_tid];
    issue_hs   = sel_found && insn_rdy_i;
  end

  // Next-state for thread FSMs, buffers, round-robin pointer and lock.
  always_comb begin
    for (int t = 0; t < NUM_THREADS_P; t++) begin
      state_d[t] = state_q[t];
      insn_d[t]  = insn_q[t];
      pc_d[t]    = pc_q[t];
      case (state_q[t])
        ST_EMPTY: begin
          if (fetch_hit[t]) begin
            state_d[t] = ST_READY;
            insn_d[t]  = fetch_insn_i;
            pc_d[t]    = fetch_pc_i;
          end else begin
            state_d[t] = ST_EMPTY;
          end
        end
        ST_READY: begin
          if (issue_hs && (sel_tid == TID_WIDTH_LP'(t))) begin
            state_d[t] = (dec_b_is_branch_i || dec_b_is_jump_i) ? ST_WAIT_BR : ST_EMPTY;
          end else begin
            state_d[t] = ST_READY;
          end
        end
        ST_WAIT_BR: begin
          if (br_resolve_vld_i && (br_resolve_tid_i == TID_WIDTH_LP'(t))) begin
            state_d[t] = ST_EMPTY;
          end else begin
            state_d[t] = ST_WAIT_BR;
          end
        end
        default: state_d[t] = ST_EMPTY;
      endcase
      if (flush_vld_i && (flush_tid_i == TID_WIDTH_LP'(t))) begin
        state_d[t] = ST_EMPTY;
      end else begin
        state_d[t] = state_d[t];
      end
    end
    last_grant_d = issue_hs ? sel_tid : last_grant_q;
    // Back-pressure pins the current choice; any handshake or idle cycle drops it.
    lock_vld_d   = sel_found && !insn_rdy_i;
    lock_tid_d   = sel_tid;
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int t = 0; t < NUM_THREADS_P; t++) begin
        state_q[t] <= ST_EMPTY;
      end
      last_grant_q <= TID_WIDTH_LP'(NUM_THREADS_P - 1);
      lock_vld_q   <= 1'b0;
      lock_tid_q   <= '0;
    end else begin
      for (int t = 0; t < NUM_THREADS_P; t++) begin
        state_q[t] <= state_d[t];
      end
      last_grant_q <= last_grant_d;
      lock_vld_q   <= lock_vld_d;
      lock_tid_q   <= lock_tid_d;
    end
  end

  // Payload buffers carry no reset; they are only read while READY.
  always_ff @(posedge clk_i) begin
    for (int t = 0; t < NUM_THREADS_P; t++) begin
      insn_q[t] <= insn_d[t];
      pc_q[t]   <= pc_d[t];
    end
  end

endmodule

// File: tb/tb_mrv1_issue_sched.sv
// Self-checking bench for mrv1_issue_sched: directed scenario tasks plus a randomized
// run compared against a behavioural thread/round-robin model.
module tb_mrv1_issue_sched;
  localparam int N   = 8;
  localparam int PCW = 32;
  localparam int TW  = $clog2(N);

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [N-1:0]   thread_en_i;
  logic           fetch_vld_i;
  logic [31:0]    fetch_insn_i;
  logic [PCW-1:0] fetch_pc_i;
  logic [TW-1:0]  fetch_tid_i;
  logic [N-1:0]   fetch_rdy_o;
  logic           insn_vld_o;
  logic [31:0]    insn_o;
  logic [PCW-1:0] insn_pc_o;
  logic [TW-1:0]  insn_tid_o;
  logic           insn_rdy_i;
  logic           dec_b_is_branch_i;
  logic           dec_b_is_jump_i;
  logic           br_resolve_vld_i;
  logic [TW-1:0]  br_resolve_tid_i;
  logic           flush_vld_i;
  logic [TW-1:0]  flush_tid_i;
  logic [N-1:0]   thread_idle_o;

  int checks   = 0;
  int failures = 0;

  mrv1_issue_sched #(.PC_WIDTH_P(PCW), .NUM_THREADS_P(N)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .thread_en_i(thread_en_i),
    .fetch_vld_i(fetch_vld_i), .fetch_insn_i(fetch_insn_i), .fetch_pc_i(fetch_pc_i),
    .fetch_tid_i(fetch_tid_i), .fetch_rdy_o(fetch_rdy_o),
    .insn_vld_o(insn_vld_o), .insn_o(insn_o), .insn_pc_o(insn_pc_o), .insn_tid_o(insn_tid_o),
    .insn_rdy_i(insn_rdy_i), .dec_b_is_branch_i(dec_b_is_branch_i), .dec_b_is_jump_i(dec_b_is_jump_i),
    .br_resolve_vld_i(br_resolve_vld_i), .br_resolve_tid_i(br_resolve_tid_i),
    .flush_vld_i(flush_vld_i), .flush_tid_i(flush_tid_i), .thread_idle_o(thread_idle_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic quiet_inputs();
    fetch_vld_i = 1'b0; fetch_insn_i = '0; fetch_pc_i = '0; fetch_tid_i = '0;
    insn_rdy_i = 1'b1; dec_b_is_branch_i = 1'b0; dec_b_is_jump_i = 1'b0;
    br_resolve_vld_i = 1'b0; br_resolve_tid_i = '0; flush_vld_i = 1'b0; flush_tid_i = '0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; thread_en_i = '1; quiet_inputs();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic fetch(input int tid, input logic [31:0] insn, input logic [PCW-1:0] pc);
    fetch_vld_i = 1'b1; fetch_tid_i = TW'(tid); fetch_insn_i = insn; fetch_pc_i = pc;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; thread_en_i = '1; quiet_inputs(); fetch(0, 32'h1, 32'h0);
    #1;
    checks++; if (fetch_rdy_o !== 8'h00) begin failures++; $display("FAIL reset_fetch_rdy: got %0h expected 0", fetch_rdy_o); end
    tick();
    #1;
    checks++; if (insn_vld_o !== 1'b0) begin failures++; $display("FAIL reset_insn_vld: got %0b expected 0", insn_vld_o); end
    checks++; if (thread_idle_o !== 8'hFF) begin failures++; $display("FAIL reset_idle: got %0h expected ff", thread_idle_o); end
    rst_i = 1'b0; fetch_vld_i = 1'b0;
    #1;
    checks++; if (fetch_rdy_o !== 8'hFF) begin failures++; $display("FAIL post_reset_fetch_rdy: got %0h expected ff", fetch_rdy_o); end
    tick();
  endtask

  task automatic test_in_order();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) fetch(i, 32'hA000_0000 | 32'(i), 32'h1000 + 32'(4 * i));
      else fetch_vld_i = 1'b0;
      #1;
      if (i == 0) begin
        checks++; if (insn_vld_o !== 1'b0) begin failures++; $display("FAIL inorder_first_vld: got %0b expected 0", insn_vld_o); end
      end else begin
        checks++; if (insn_vld_o !== 1'b1 || insn_tid_o !== TW'(i - 1)) begin
          failures++; $display("FAIL inorder_tid[%0d]: got vld=%0b tid=%0d expected vld=1 tid=%0d", i, insn_vld_o, insn_tid_o, i - 1); end
        checks++; if (insn_o !== (32'hA000_0000 | 32'(i - 1)) || insn_pc_o !== 32'h1000 + 32'(4 * (i - 1))) begin
          failures++; $display("FAIL inorder_payload[%0d]: got %0h/%0h", i, insn_o, insn_pc_o); end
      end
      tick();
    end
    #1;
    checks++; if (insn_vld_o !== 1'b0) begin failures++; $display("FAIL inorder_drain: got %0b expected 0", insn_vld_o); end
  endtask

  task automatic rr_case(input int first, input int a, input int b);
    do_reset();
    fetch(first, 32'hF0, 32'h0);
    tick();
    fetch_vld_i = 1'b0;
    #1;
    checks++; if (insn_tid_o !== TW'(first) || insn_vld_o !== 1'b1) begin
      failures++; $display("FAIL rr_setup: got tid=%0d expected %0d", insn_tid_o, first); end
    tick();
    insn_rdy_i = 1'b0;
    fetch(5, 32'h55, 32'h500);
    tick();
    thread_en_i[5] = 1'b0;
    fetch(2, 32'h22, 32'h200);
    tick();
    thread_en_i[2] = 1'b0; fetch_vld_i = 1'b0;
    #1;
    checks++; if (insn_vld_o !== 1'b0 || thread_idle_o[5] !== 1'b0) begin
      failures++; $display("FAIL rr_hold: got vld=%0b idle5=%0b expected 0/0", insn_vld_o, thread_idle_o[5]); end
    tick();
    thread_en_i = '1; insn_rdy_i = 1'b1;
    #1;
    checks++; if (insn_vld_o !== 1'b1 || insn_tid_o !== TW'(a)) begin
      failures++; $display("FAIL rr_first_after_%0d: got tid=%0d expected %0d", first, insn_tid_o, a); end
    tick();
    #1;
    checks++; if (insn_vld_o !== 1'b1 || insn_tid_o !== TW'(b)) begin
      failures++; $display("FAIL rr_second_after_%0d: got tid=%0d expected %0d", first, insn_tid_o, b); end
    tick();
  endtask

  task automatic test_round_robin();
    rr_case(2, 5, 2);
    rr_case(6, 2, 5);
  endtask

  task automatic test_branch_wait();
    do_reset();
    fetch(1, 32'h0000_006F, 32'h40);
    tick();
    fetch_vld_i = 1'b0; dec_b_is_jump_i = 1'b1;
    #1;
    checks++; if (insn_vld_o !== 1'b1 || insn_tid_o !== TW'(1)) begin
      failures++; $display("FAIL br_issue: got vld=%0b tid=%0d expected 1/1", insn_vld_o, insn_tid_o); end
    tick();
    dec_b_is_jump_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      br_resolve_vld_i = (k == 1); br_resolve_tid_i = TW'(2);
      #1;
      checks++; if (fetch_rdy_o[1] !== 1'b0 || thread_idle_o[1] !== 1'b0) begin
        failures++; $display("FAIL br_wait[%0d]: got rdy=%0b idle=%0b expected 0/0", k, fetch_rdy_o[1], thread_idle_o[1]); end
      tick();
    end
    br_resolve_vld_i = 1'b1; br_resolve_tid_i = TW'(1);
    #1;
    checks++; if (fetch_rdy_o[1] !== 1'b0) begin failures++; $display("FAIL br_resolve_cycle: got %0b expected 0", fetch_rdy_o[1]); end
    tick();
    br_resolve_vld_i = 1'b0;
    #1;
    checks++; if (fetch_rdy_o[1] !== 1'b1) begin failures++; $display("FAIL br_resolved: got %0b expected 1", fetch_rdy_o[1]); end
  endtask

  task automatic test_stall_lock();
    do_reset();
    fetch(4, 32'hB4B4_0004, 32'h8004);
    tick();
    insn_rdy_i = 1'b0;
    fetch(0, 32'hB0B0_0000, 32'h8000);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (insn_vld_o !== 1'b1 || insn_tid_o !== TW'(4) || insn_o !== 32'hB4B4_0004 || insn_pc_o !== 32'h8004) begin
        failures++; $display("FAIL stall_lock[%0d]: got vld=%0b tid=%0d insn=%0h pc=%0h expected 1/4/b4b40004/8004", k, insn_vld_o, insn_tid_o, insn_o, insn_pc_o); end
      tick();
      fetch_vld_i = 1'b0;
    end
    insn_rdy_i = 1'b1;
    #1;
    checks++; if (insn_tid_o !== TW'(4)) begin failures++; $display("FAIL stall_accept: got tid=%0d expected 4", insn_tid_o); end
    tick();
    #1;
    checks++; if (insn_vld_o !== 1'b1 || insn_tid_o !== TW'(0) || insn_o !== 32'hB0B0_0000) begin
      failures++; $display("FAIL stall_next: got vld=%0b tid=%0d insn=%0h expected 1/0/b0b00000", insn_vld_o, insn_tid_o, insn_o); end
    tick();
  endtask

  task automatic test_flush_lock();
    do_reset();
    fetch(3, 32'h33, 32'h300);
    tick();
    insn_rdy_i = 1'b0;
    fetch(5, 32'h55, 32'h500);
    tick();
    fetch_vld_i = 1'b0;
    #1;
    checks++; if (insn_tid_o !== TW'(3)) begin failures++; $display("FAIL flush_locked: got tid=%0d expected 3", insn_tid_o); end
    flush_vld_i = 1'b1; flush_tid_i = TW'(3);
    #1;
    checks++; if (insn_vld_o !== 1'b1 || insn_tid_o !== TW'(5)) begin
      failures++; $display("FAIL flush_cycle: got vld=%0b tid=%0d expected 1/5", insn_vld_o, insn_tid_o); end
    tick();
    flush_vld_i = 1'b0;
    #1;
    checks++; if (thread_idle_o[3] !== 1'b1 || fetch_rdy_o[3] !== 1'b1) begin
      failures++; $display("FAIL flush_empty: got idle=%0b rdy=%0b expected 1/1", thread_idle_o[3], fetch_rdy_o[3]); end
    insn_rdy_i = 1'b1;
    #1;
    checks++; if (insn_tid_o !== TW'(5) || insn_o !== 32'h55) begin
      failures++; $display("FAIL flush_next: got tid=%0d insn=%0h expected 5/55", insn_tid_o, insn_o); end
    tick();
  endtask

  task automatic test_disable();
    do_reset();
    fetch(2, 32'hC2C2_C2C2, 32'h2222);
    tick();
    thread_en_i[2] = 1'b0; fetch_vld_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (insn_vld_o !== 1'b0) begin failures++; $display("FAIL dis_no_issue[%0d]: got %0b expected 0", k, insn_vld_o); end
      tick();
    end
    checks++; if (thread_idle_o[2] !== 1'b0 || fetch_rdy_o[2] !== 1'b0) begin
      failures++; $display("FAIL dis_retain: got idle=%0b rdy=%0b expected 0/0", thread_idle_o[2], fetch_rdy_o[2]); end
    fetch(3, 32'hC3, 32'h3333);
    tick();
    fetch_vld_i = 1'b0;
    #1;
    checks++; if (insn_tid_o !== TW'(3) || insn_vld_o !== 1'b1) begin
      failures++; $display("FAIL dis_other: got tid=%0d expected 3", insn_tid_o); end
    tick();
    thread_en_i = '1;
    #1;
    checks++; if (insn_vld_o !== 1'b1 || insn_tid_o !== TW'(2) || insn_o !== 32'hC2C2_C2C2 || insn_pc_o !== 32'h2222) begin
      failures++; $display("FAIL dis_reenable: got vld=%0b tid=%0d insn=%0h pc=%0h", insn_vld_o, insn_tid_o, insn_o, insn_pc_o); end
    tick();
  endtask

  // Behavioural model state for the randomized run (0 empty, 1 ready, 2 waiting on branch).
  int             m_state [N];
  logic [31:0]    m_insn  [N];
  logic [PCW-1:0] m_pc    [N];
  int             m_last;
  bit             m_lock;
  int             m_lock_tid;

  task automatic test_random();
    logic [N-1:0] e_rdy, e_idle, e_elig;
    bit           e_vld;
    int           e_sel, best, d, nw;
    do_reset();
    for (int t = 0; t < N; t++) m_state[t] = 0;
    m_last = N - 1; m_lock = 1'b0; m_lock_tid = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      rst_i = ($urandom_range(0, 59) == 0);
      for (int t = 0; t < N; t++) thread_en_i[t] = ($urandom_range(0, 7) != 0);
      fetch_vld_i = ($urandom_range(0, 1) == 1);
      fetch_tid_i = TW'($urandom_range(0, N - 1));
      fetch_insn_i = $urandom; fetch_pc_i = $urandom;
      insn_rdy_i = ($urandom_range(0, 9) < 7);
      dec_b_is_branch_i = ($urandom_range(0, 3) == 0);
      dec_b_is_jump_i = ($urandom_range(0, 3) == 0);
      br_resolve_vld_i = ($urandom_range(0, 2) == 0);
      br_resolve_tid_i = TW'($urandom_range(0, N - 1));
      flush_vld_i = ($urandom_range(0, 9) == 0);
      flush_tid_i = TW'($urandom_range(0, N - 1));
      #1;
      for (int t = 0; t < N; t++) begin
        e_idle[t] = (m_state[t] == 0);
        e_rdy[t]  = !rst_i && (m_state[t] == 0) && thread_en_i[t];
        e_elig[t] = !rst_i && (m_state[t] == 1) && thread_en_i[t] && !(flush_vld_i && int'(flush_tid_i) == t);
      end
      e_vld = 1'b0; e_sel = 0; best = N;
      if (m_lock && e_elig[m_lock_tid]) begin
        e_vld = 1'b1; e_sel = m_lock_tid;
      end else begin
        for (int t = 0; t < N; t++) begin
          d = (t - m_last - 1 + 2 * N) % N;
          if (e_elig[t] && d < best) begin best = d; e_sel = t; e_vld = 1'b1; end
        end
      end
      checks++; if (fetch_rdy_o !== e_rdy) begin failures++; $display("FAIL rand_fetch_rdy@%0d: got %0h expected %0h", cyc, fetch_rdy_o, e_rdy); end
      checks++; if (thread_idle_o !== e_idle) begin failures++; $display("FAIL rand_idle@%0d: got %0h expected %0h", cyc, thread_idle_o, e_idle); end
      checks++; if (insn_vld_o !== e_vld) begin failures++; $display("FAIL rand_vld@%0d: got %0b expected %0b", cyc, insn_vld_o, e_vld); end
      if (e_vld) begin
        checks++; if (insn_tid_o !== TW'(e_sel) || insn_o !== m_insn[e_sel] || insn_pc_o !== m_pc[e_sel]) begin
          failures++; $display("FAIL rand_issue@%0d: got tid=%0d insn=%0h pc=%0h expected tid=%0d insn=%0h pc=%0h",
                               cyc, insn_tid_o, insn_o, insn_pc_o, e_sel, m_insn[e_sel], m_pc[e_sel]); end
      end
      if (rst_i) begin
        for (int t = 0; t < N; t++) m_state[t] = 0;
        m_last = N - 1; m_lock = 1'b0;
      end else begin
        for (int t = 0; t < N; t++) begin
          nw = m_state[t];
          if (fetch_vld_i && int'(fetch_tid_i) == t && e_rdy[t]) begin
            nw = 1; m_insn[t] = fetch_insn_i; m_pc[t] = fetch_pc_i;
          end
          if (e_vld && insn_rdy_i && e_sel == t) nw = (dec_b_is_branch_i || dec_b_is_jump_i) ? 2 : 0;
          if (br_resolve_vld_i && int'(br_resolve_tid_i) == t && m_state[t] == 2) nw = 0;
          if (flush_vld_i && int'(flush_tid_i) == t) nw = 0;
          m_state[t] = nw;
        end
        if (e_vld && insn_rdy_i) m_last = e_sel;
        m_lock = e_vld && !insn_rdy_i;
        m_lock_tid = e_sel;
      end
      tick();
    end
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; thread_en_i = '1; quiet_inputs();
    @(negedge clk_i);
    test_reset();
    test_in_order();
    test_round_robin();
    test_branch_wait();
    test_stall_lock();
    test_flush_lock();
    test_disable();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
